// File: rtl/multicycle_ctrl_pkg.sv
// Shared control package: ALU function codes, controller state, opcode
// constants, immediate formats and register-file write-back selects.
package ALU_FNS;

    // ALU operation, encoded as {alt, funct3} so R-type instructions map directly
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_fn_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TARGET,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    typedef enum logic [2:0] {
        IC_OP,
        IC_OP_IMM,
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_JAL,
        IC_LUI,
        IC_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] RF_WR_ALU = 2'd0;
    localparam logic [1:0] RF_WR_MEM = 2'd1;
    localparam logic [1:0] RF_WR_PC  = 2'd2;

    // Only ADD/SUB and SRL/SRA have an alternate form; elsewhere alt is ignored
    function automatic alu_fn_t alu_fn_from_funct(input logic [2:0] funct3, input logic alt);
        logic use_alt;
        use_alt = alt && ((funct3 == 3'b000) || (funct3 == 3'b101));
        return alu_fn_t'({use_alt, funct3});
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode -> class, ALU function,
// immediate format and legality.
import ALU_FNS::*;

module ctrl_decode #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] instr,
    output instr_class_t     iclass,
    output alu_fn_t          alu_fn,
    output imm_type_t        imm_type,
    output logic             legal
);

    logic [2:0] funct3;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    // Register and immediate fields are consumed by the datapath, not here
    assign unused_bits = ^{instr[WIDTH-1:31], instr[29:15], instr[11:7]};

    // Classify the opcode and pick the ALU operation used in EXEC
    always_comb begin
        iclass   = IC_ILLEGAL;
        alu_fn   = ALU_ADD;
        imm_type = IMM_I;
        legal    = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                iclass = IC_OP;
                alu_fn = alu_fn_from_funct(funct3, instr[30]);
                legal  = 1'b1;
            end
            OPC_OP_IMM: begin
                // instr[30] is an immediate bit except for SRAI
                iclass = IC_OP_IMM;
                alu_fn = alu_fn_from_funct(funct3, (funct3 == 3'b101) && instr[30]);
                legal  = 1'b1;
            end
            OPC_LOAD: begin
                iclass = IC_LOAD;
                legal  = 1'b1;
            end
            OPC_STORE: begin
                iclass   = IC_STORE;
                imm_type = IMM_S;
                legal    = 1'b1;
            end
            OPC_BRANCH: begin
                // Only BEQ/BNE are implemented; other compares trap
                iclass   = IC_BRANCH;
                alu_fn   = ALU_SUB;
                imm_type = IMM_B;
                legal    = (funct3[2:1] == 2'b00);
            end
            OPC_JAL: begin
                iclass   = IC_JAL;
                imm_type = IMM_J;
                legal    = 1'b1;
            end
            OPC_LUI: begin
                iclass   = IC_LUI;
                imm_type = IMM_U;
                legal    = 1'b1;
            end
            default: begin
                iclass = IC_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory and
// write-back sequencing with a single memory port and an illegal-opcode trap.
// Optional feature macro MULTICYCLE_CTRL_PERF_EN adds cycle/instret counters.
import ALU_FNS::*;

module multicycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [2:0]       imm_type,
    output alu_fn_t          alu_fn,
    output logic             rf_wr_en,
    output logic [1:0]       rf_wr_sel,
    output logic             illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt
`endif
);

    ctrl_state_t  state_reg;
    ctrl_state_t  state_next;

    instr_class_t dec_class;
    alu_fn_t      dec_alu_fn;
    imm_type_t    dec_imm_type;
    logic         dec_legal;

    imm_type_t    imm_sel;
    logic         rd_nz;
    logic         exec_src_a;
    logic         exec_src_b;
    logic         branch_taken;

    ctrl_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .instr    (instr),
        .iclass   (dec_class),
        .alu_fn   (dec_alu_fn),
        .imm_type (dec_imm_type),
        .legal    (dec_legal)
    );

    // Writes to x0 are dropped at the source
    assign rd_nz        = |instr[11:7];
    // JAL adds to the old PC; OP and BRANCH use rs2 instead of the immediate
    assign exec_src_a   = (dec_class == IC_JAL);
    assign exec_src_b   = (dec_class == IC_OP) || (dec_class == IC_BRANCH);
    // funct3[0] distinguishes BNE from BEQ
    assign branch_taken = instr[12] ? !alu_zero : alu_zero;
    assign imm_type     = imm_sel;

    // State register; reset always lands in FETCH, even mid-request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_next   = state_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b1;
        imm_sel      = IMM_I;
        alu_fn       = ALU_ADD;
        rf_wr_en     = 1'b0;
        rf_wr_sel    = RF_WR_ALU;
        illegal      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en      = 1'b1;
                    pc_en      = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                alu_src_a = exec_src_a;
                alu_src_b = exec_src_b;
                imm_sel   = dec_imm_type;
                alu_fn    = dec_alu_fn;
                case (dec_class)
                    IC_OP, IC_OP_IMM, IC_LUI: state_next = ST_WB;
                    IC_LOAD, IC_STORE:        state_next = ST_MEM;
                    IC_BRANCH:                state_next = branch_taken ? ST_TARGET : ST_FETCH;
                    IC_JAL: begin
                        rf_wr_en   = rd_nz;
                        rf_wr_sel  = RF_WR_PC;
                        pc_en      = 1'b1;
                        pc_sel     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    default:                  state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                // Address computation is held stable for the whole request
                alu_src_a    = exec_src_a;
                alu_src_b    = exec_src_b;
                imm_sel      = dec_imm_type;
                alu_fn       = dec_alu_fn;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec_class == IC_STORE);
                if (mem_ack) begin
                    state_next = (dec_class == IC_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                // Keep the ALU result valid while it is written back
                alu_src_a  = exec_src_a;
                alu_src_b  = exec_src_b;
                imm_sel    = dec_imm_type;
                alu_fn     = dec_alu_fn;
                rf_wr_en   = rd_nz;
                rf_wr_sel  = (dec_class == IC_LOAD) ? RF_WR_MEM : RF_WR_ALU;
                state_next = ST_FETCH;
            end
            ST_TARGET: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 1'b0;
                imm_sel    = IMM_B;
                alu_fn     = ALU_ADD;
                pc_en      = 1'b1;
                pc_sel     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instret_cnt_reg;

    // Cycle count stops while trapped; an instruction retires on every return to FETCH
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg != ST_TRAP) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if ((state_reg != ST_FETCH) && (state_next == ST_FETCH)) begin
                instret_cnt_reg <= instret_cnt_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: builds the expected per-cycle
// control trace of each instruction from its class and memory/branch stimulus.
import ALU_FNS::*;

module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_en;
        logic       pc_en;
        logic       pc_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_type;
        logic [3:0] alu_fn;
        logic       rf_wr_en;
        logic [1:0] rf_wr_sel;
        logic       illegal;
    } outs_t;

    // ALU control expected while an instruction is being executed
    typedef struct packed {
        logic       src_a;
        logic       src_b;
        logic [2:0] imm;
        logic [3:0] fn;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel;
    logic        alu_src_a, alu_src_b, rf_wr_en, illegal;
    logic [2:0]  imm_type;
    alu_fn_t     alu_fn;
    logic [1:0]  rf_wr_sel;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t exp_cur;
    outs_t act;
    logic  exp_valid = 1'b0;
    string exp_name = "";
    int    ncyc;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .alu_zero     (alu_zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_type     (imm_type),
        .alu_fn       (alu_fn),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_sel    (rf_wr_sel),
        .illegal      (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    assign act = '{mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, alu_src_a,
                   alu_src_b, imm_type, 4'(alu_fn), rf_wr_en, rf_wr_sel, illegal};

    // Single compare point, mid-cycle, against the currently expected outputs
    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (act !== exp_cur) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", exp_name, act, exp_cur);
            end else begin
                $display("ok   %s: %h", exp_name, act);
            end
        end
    end

    task automatic chk_int(input string nm, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end else begin
            $display("ok   %s: %0d", nm, got);
        end
    endtask

    // One clock cycle: apply inputs, publish expectation, advance
    task automatic step(input outs_t e, input logic ack, input logic zero, input logic r,
                        input string nm);
        mem_ack   = ack;
        alu_zero  = zero;
        rst       = r;
        exp_cur   = e;
        exp_name  = nm;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t idle_outs();
        outs_t o;
        o = '0;
        o.alu_src_b = 1'b1;
        return o;
    endfunction

    function automatic outs_t with_ctl(input ctl_t c);
        outs_t o;
        o = idle_outs();
        o.alu_src_a = c.src_a;
        o.alu_src_b = c.src_b;
        o.imm_type  = c.imm;
        o.alu_fn    = c.fn;
        return o;
    endfunction

    // Expected trace of one instruction: fetch (with waits), decode, then the
    // class-specific execute/memory/write-back/target cycles.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int fwait,
                             input int mwait, input logic zero, input ctl_t c,
                             input logic rst_in_mem, output int cycles);
        outs_t e;
        logic  rd_nz, taken;
        logic [6:0] op;
        cycles = 0;
        op     = ins[6:0];
        rd_nz  = (ins[11:7] != 5'd0);
        for (int i = 0; i < fwait; i++) begin
            e = idle_outs(); e.mem_req = 1'b1;
            step(e, 1'b0, zero, 1'b1, {nm, "/fetch_wait"}); cycles++;
        end
        e = idle_outs(); e.mem_req = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
        step(e, 1'b1, zero, 1'b1, {nm, "/fetch"}); cycles++;
        instr = ins;
        // Acks outside a memory request must be ignored
        step(idle_outs(), 1'b1, zero, 1'b1, {nm, "/decode"}); cycles++;
        e = with_ctl(c);
        if (op == 7'b1101111) begin
            e.rf_wr_en = rd_nz; e.rf_wr_sel = 2'd2; e.pc_en = 1'b1; e.pc_sel = 1'b1;
            step(e, 1'b1, zero, 1'b1, {nm, "/exec"}); cycles++;
        end else if (op == 7'b1100011) begin
            taken = ins[12] ? !zero : zero;
            step(e, 1'b1, zero, 1'b1, {nm, "/exec"}); cycles++;
            if (taken) begin
                e = idle_outs(); e.alu_src_a = 1'b1; e.alu_src_b = 1'b0;
                e.imm_type = 3'd2; e.pc_en = 1'b1; e.pc_sel = 1'b1;
                step(e, 1'b1, zero, 1'b1, {nm, "/target"}); cycles++;
            end
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            step(e, 1'b1, zero, 1'b1, {nm, "/exec"}); cycles++;
            e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == 7'b0100011);
            if (rst_in_mem) begin
                step(e, 1'b0, zero, 1'b0, {nm, "/mem_rst"}); cycles++;
                return;
            end
            for (int i = 0; i < mwait; i++) begin
                step(e, 1'b0, zero, 1'b1, {nm, "/mem_wait"}); cycles++;
            end
            step(e, 1'b1, zero, 1'b1, {nm, "/mem"}); cycles++;
            if (op == 7'b0000011) begin
                e = with_ctl(c); e.rf_wr_en = rd_nz; e.rf_wr_sel = 2'd1;
                step(e, 1'b1, zero, 1'b1, {nm, "/wb"}); cycles++;
            end
        end else begin
            step(e, 1'b1, zero, 1'b1, {nm, "/exec"}); cycles++;
            e.rf_wr_en = rd_nz;
            step(e, 1'b1, zero, 1'b1, {nm, "/wb"}); cycles++;
        end
    endtask

    // ALU controls by hand: {src_a, src_b, imm_type, alu_fn}
    localparam ctl_t C_ADD  = '{1'b0, 1'b1, 3'd0, 4'h0};
    localparam ctl_t C_SUB  = '{1'b0, 1'b1, 3'd0, 4'h8};
    localparam ctl_t C_LDI  = '{1'b0, 1'b0, 3'd0, 4'h0};
    localparam ctl_t C_SRAI = '{1'b0, 1'b0, 3'd0, 4'hD};
    localparam ctl_t C_ST   = '{1'b0, 1'b0, 3'd1, 4'h0};
    localparam ctl_t C_BR   = '{1'b0, 1'b1, 3'd2, 4'h8};
    localparam ctl_t C_LUI  = '{1'b0, 1'b0, 3'd3, 4'h0};
    localparam ctl_t C_JAL  = '{1'b1, 1'b0, 3'd4, 4'h0};

    initial begin
        outs_t e;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk_int("perf_cycle_after_reset", int'(cycle_cnt), 0);
        chk_int("perf_instret_after_reset", int'(instret_cnt), 0);
`endif
        // First fetch waits one cycle, exposing the reset output values
        run_instr("add", 32'h002081B3, 1, 0, 1'b0, C_ADD, 1'b0, ncyc);
        chk_int("add_cycles", ncyc, 5);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk_int("perf_cycle_after_add", int'(cycle_cnt), 5);
        chk_int("perf_instret_after_add", int'(instret_cnt), 1);
`endif
        run_instr("lw", 32'h0080A283, 0, 2, 1'b0, C_LDI, 1'b0, ncyc);
        chk_int("lw_cycles", ncyc, 7);
        run_instr("beq_taken", 32'h00208863, 0, 0, 1'b1, C_BR, 1'b0, ncyc);
        chk_int("beq_taken_cycles", ncyc, 4);
        run_instr("beq_not_taken", 32'h00208863, 0, 0, 1'b0, C_BR, 1'b0, ncyc);
        chk_int("beq_not_taken_cycles", ncyc, 3);
        run_instr("bne_taken", 32'h00209463, 0, 0, 1'b0, C_BR, 1'b0, ncyc);
        chk_int("bne_taken_cycles", ncyc, 4);
        run_instr("bne_not_taken", 32'h00209463, 0, 0, 1'b1, C_BR, 1'b0, ncyc);
        chk_int("bne_not_taken_cycles", ncyc, 3);
        run_instr("addi_x0", 32'h00500013, 0, 0, 1'b0, C_LDI, 1'b0, ncyc);
        chk_int("addi_x0_cycles", ncyc, 4);
        run_instr("jal", 32'h008000EF, 0, 0, 1'b0, C_JAL, 1'b0, ncyc);
        chk_int("jal_cycles", ncyc, 3);
        run_instr("lui", 32'h123453B7, 0, 0, 1'b0, C_LUI, 1'b0, ncyc);
        chk_int("lui_cycles", ncyc, 4);
        run_instr("sub", 32'h40628233, 0, 0, 1'b0, C_SUB, 1'b0, ncyc);
        chk_int("sub_cycles", ncyc, 4);
        run_instr("srai", 32'h40315093, 0, 0, 1'b0, C_SRAI, 1'b0, ncyc);
        chk_int("srai_cycles", ncyc, 4);
        run_instr("sw", 32'h0020A223, 0, 0, 1'b0, C_ST, 1'b0, ncyc);
        chk_int("sw_cycles", ncyc, 4);
        // Reset in the middle of a store's memory request
        run_instr("sw_rst", 32'h0020A223, 0, 0, 1'b0, C_ST, 1'b1, ncyc);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk_int("perf_cycle_after_mem_rst", int'(cycle_cnt), 0);
        chk_int("perf_instret_after_mem_rst", int'(instret_cnt), 0);
`endif
        run_instr("add_after_rst", 32'h002081B3, 0, 0, 1'b0, C_ADD, 1'b0, ncyc);
        chk_int("add_after_rst_cycles", ncyc, 4);
        // Unsupported opcode traps and stays trapped despite memory acks
        e = idle_outs(); e.mem_req = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
        step(e, 1'b1, 1'b0, 1'b1, "trap/fetch");
        instr = 32'h0000007F;
        step(idle_outs(), 1'b0, 1'b0, 1'b1, "trap/decode");
        e = idle_outs(); e.illegal = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(e, 1'(i % 2), 1'b0, 1'b1, "trap/hold");
        end
        step(e, 1'b0, 1'b0, 1'b0, "trap/rst");
        e = idle_outs(); e.mem_req = 1'b1;
        step(e, 1'b0, 1'b0, 1'b1, "trap/after_rst_fetch");
        // BLT lies outside the BEQ/BNE branch set and traps
        e = idle_outs(); e.mem_req = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
        step(e, 1'b1, 1'b0, 1'b1, "blt/fetch");
        instr = 32'h0020C463;
        step(idle_outs(), 1'b0, 1'b0, 1'b1, "blt/decode");
        e = idle_outs(); e.illegal = 1'b1;
        step(e, 1'b1, 1'b0, 1'b1, "blt/trap");
        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I core datapath. Sequences instruction fetch, decode, execute, memory access and register write-back by driving the datapath's enables, mux selects and ALU function. Handshakes with a single instruction/data memory port, and traps on unsupported opcodes. Sits beside `datapath`; its outputs replace that block's free-running `sel`/`en`/`wr_en` inputs.

## Interface
- `WIDTH`, 32: datapath/instruction width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `instr`  in  WIDTH  current IR contents.
- `alu_zero`  in  1  ALU result == 0.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  request is a store.
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result.
- `ir_en`  out  1  load IR.
- `pc_en`  out  1  load PC.
- `pc_sel`  out  1  0 = PC+4, 1 = ALU result.
- `alu_src_a`  out  1  0 = rs1, 1 = old PC (PC of current instruction).
- `alu_src_b`  out  1  1 = rs2, 0 = immediate (datapath `sel` polarity).
- `imm_type`  out  3  immediate format: I/S/B/U/J.
- `alu_fn`  out  `alu_fn_t`  ALU operation.
- `rf_wr_en`  out  1  register-file write.
- `rf_wr_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC.
- `illegal`  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TARGET, TRAP.
- FETCH:
  - `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - On `mem_ack`: `ir_en`=1, `pc_en`=1, `pc_sel`=0, go to DECODE. Otherwise stay.
- DECODE: classify `instr[6:0]`.
  - Supported opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000/001 only), JAL 1101111, LUI 0110111.
  - Anything else goes to TRAP.
- EXEC:
  - OP: `alu_src_b`=1, `alu_fn` from funct3/funct7.
  - OP-IMM: `alu_src_b`=0, `imm_type`=I.
  - LUI: `alu_src_a`=rs1 forced x0 semantics via `imm_type`=U, ADD.
  - LOAD/STORE: ADD rs1+imm (I/S), then MEM.
  - OP/OP-IMM/LUI go to WB.
  - BRANCH: SUB rs1-rs2.
    - Taken (BEQ & `alu_zero`, or BNE & !`alu_zero`) goes to TARGET.
    - Not taken goes to FETCH.
  - JAL:
    - ALU computes old PC + J-imm.
    - Assert `rf_wr_en` with `rf_wr_sel`=2.
    - Assert `pc_en` with `pc_sel`=1.
    - Go to FETCH.
- MEM:
  - `mem_req`=1, `mem_addr_sel`=1, `mem_we` = STORE.
  - On `mem_ack`: LOAD goes to WB; STORE goes to FETCH.
- WB: `rf_wr_en`=1. `rf_wr_sel` is 1 for LOAD, 0 otherwise. Then go to FETCH.
- TARGET: ALU computes old PC + B-imm, `pc_en`=1, `pc_sel`=1, then go to FETCH.
- TRAP:
  - `illegal`=1, all enables 0.
  - Held until reset.
- `rf_wr_en` is suppressed whenever rd (`instr[11:7]`) == 0.
- `mem_ack` outside FETCH/MEM is ignored.

## Timing
- Reset: `rst`=0 at any edge forces FETCH next cycle, regardless of current state, including mid-memory-request.
- Output values after reset: all outputs 0, except `alu_src_b`=1 and `mem_req`=1 (FETCH).
- All outputs are a combinational function of state, `instr`, `alu_zero` and `mem_ack` (Moore plus the `mem_ack`/`alu_zero`-qualified enables).
- Latencies with zero-wait memory (ack in the request cycle):
  - OP / OP-IMM / LUI: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Branch not taken: 3 cycles.
  - Branch taken: 4 cycles.
  - JAL: 3 cycles.
- Each memory wait cycle adds 1.
- `mem_req` never drops before `mem_ack`, except on reset.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined: adds two output ports, `cycle_cnt` and `instret_cnt`, both 32 bits.
  - Reset to 0; wrap modulo 2^32.
  - `cycle_cnt` increments every non-reset cycle except in TRAP.
  - `instret_cnt` increments on each transition into FETCH from a non-FETCH, non-reset state.
- Macro undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package `ALU_FNS` also carries:
  - `ctrl_state_t` enum.
  - Opcode localparams.
  - `imm_type_t`.
  - `rf_wr_sel` encodings.
- `alu_fn_t` stays in the existing package.
- One combinational sub-module, `ctrl_decode`: maps `instr` to instruction class, `alu_fn`, `imm_type`, and the legal flag.
- The FSM and the perf counters live in `multicycle_ctrl`.

## Test plan
- `add x3,x1,x2` (0x002081B3), ack same cycle → FETCH/DECODE/EXEC/WB in 4 cycles; `rf_wr_en`=1 only in WB; `alu_src_b`=1 in EXEC.
- `lw x5,8(x1)` with `mem_ack` delayed 2 cycles in MEM → `mem_req` held 3 cycles with `mem_addr_sel`=1, `mem_we`=0; WB `rf_wr_sel`=1; 7 cycles total.
- `beq x1,x2,+16`:
  - `alu_zero`=1 → TARGET asserts `pc_en`/`pc_sel`=1; 4 cycles.
  - `alu_zero`=0 → back to FETCH after 3 cycles with no second `pc_en`.
- `addi x0,x0,5` → no `rf_wr_en` in WB; opcode 0x7F → `illegal`=1 after DECODE, all enables 0 for 10+ cycles.
- `rst`=0 during MEM of a store with `mem_ack` low → next cycle FETCH, `mem_we`=0, `illegal` cleared; with `MULTICYCLE_CTRL_PERF_EN`, both counters read 0.
